// File: rtl/axi_llc_conf_seq.sv
// axi_llc_conf_seq: configuration front-end for the LLC RegBus port.
// After reset it issues a fixed list of boot writes, optionally polls a status
// register until the LLC reports idle, then round-robin arbitrates NumPorts
// external RegBus masters onto the single LLC config port.
// Optional feature macro: AXI_LLC_CONF_SEQ_RETRY_EN (reissue errored boot/poll
// accesses up to 3 times before declaring a boot error).
module axi_llc_conf_seq #(
    parameter int unsigned NumPorts    = 2,
    parameter int unsigned NumInit     = 4,
    parameter logic [32*((NumInit > 0) ? NumInit : 1)-1:0] InitAddr = '0,
    parameter logic [32*((NumInit > 0) ? NumInit : 1)-1:0] InitData = '0,
    parameter logic [31:0] PollAddr    = 32'h0,
    parameter logic [31:0] PollMask    = 32'h0,
    parameter int unsigned PollTimeout = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    // External RegBus masters
    input  logic [NumPorts*32-1:0] ext_req_addr_i,
    input  logic [NumPorts-1:0]    ext_req_write_i,
    input  logic [NumPorts*32-1:0] ext_req_wdata_i,
    input  logic [NumPorts*4-1:0]  ext_req_wstrb_i,
    input  logic [NumPorts-1:0]    ext_req_valid_i,
    output logic [31:0]            ext_rsp_rdata_o,
    output logic                   ext_rsp_error_o,
    output logic [NumPorts-1:0]    ext_rsp_ready_o,
    // LLC config port
    output logic [31:0]            conf_req_addr_o,
    output logic                   conf_req_write_o,
    output logic [31:0]            conf_req_wdata_o,
    output logic [3:0]             conf_req_wstrb_o,
    output logic                   conf_req_valid_o,
    input  logic [31:0]            conf_resp_rdata_i,
    input  logic                   conf_resp_error_i,
    input  logic                   conf_resp_ready_i,
    // Status
    output logic                   init_done_o,
    output logic                   init_error_o,
    output logic                   busy_o
);

`ifdef AXI_LLC_CONF_SEQ_RETRY_EN
    localparam bit RetryEn = 1'b1;
`else
    localparam bit RetryEn = 1'b0;
`endif

    localparam int unsigned PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned IdxW = (NumInit > 0) ? $clog2(NumInit + 1) : 1;
    // Only meaningful when NumInit > 0; that branch is checked first.
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumInit - 1);

    typedef enum logic [1:0] {StInitWr, StPoll, StRun, StErr} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [31:0]       poll_cnt_q, poll_cnt_d;
    logic              poll_gap_q, poll_gap_d;
    logic [1:0]        retry_q, retry_d;
    logic              armed_q;
    logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
    logic              lock_q, lock_d;
    logic [PtrW-1:0]   gnt_q, gnt_d;

    logic [31:0]       init_addr, init_data;
    logic              arb_found;
    logic [PtrW-1:0]   arb_gnt;
    logic [PtrW-1:0]   rr_next;

    // Select the current boot write entry.
    always_comb begin
        init_addr = '0;
        init_data = '0;
        if (NumInit > 0) begin
            init_addr = InitAddr[32*idx_q +: 32];
            init_data = InitData[32*idx_q +: 32];
        end
    end

    // Round-robin grant: keep the locked grant, else first valid from rr_ptr upward.
    always_comb begin
        int unsigned p;
        p         = 0;
        arb_found = 1'b0;
        arb_gnt   = gnt_q;
        if (lock_q) begin
            arb_found = 1'b1;
        end else begin
            for (int unsigned k = 0; k < NumPorts; k++) begin
                p = (32'(rr_ptr_q) + k) % NumPorts;
                if (!arb_found && ext_req_valid_i[p]) begin
                    arb_found = 1'b1;
                    arb_gnt   = PtrW'(p);
                end
            end
        end
        rr_next = (32'(arb_gnt) == NumPorts - 1) ? '0 : arb_gnt + 1'b1;
    end

    // Sequencer next state and config-port / external-port outputs.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        poll_cnt_d = poll_cnt_q;
        poll_gap_d = poll_gap_q;
        retry_d    = retry_q;
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        gnt_d      = gnt_q;

        conf_req_addr_o  = '0;
        conf_req_write_o = 1'b0;
        conf_req_wdata_o = '0;
        conf_req_wstrb_o = '0;
        conf_req_valid_o = 1'b0;
        ext_rsp_rdata_o  = '0;
        ext_rsp_error_o  = 1'b0;
        ext_rsp_ready_o  = '0;

        unique case (state_q)
            StInitWr: begin
                if (NumInit == 0) begin
                    state_d = (PollMask != '0) ? StPoll : StRun;
                end else if (armed_q) begin
                    // armed_q keeps the request off while reset is held
                    conf_req_addr_o  = init_addr;
                    conf_req_write_o = 1'b1;
                    conf_req_wdata_o = init_data;
                    conf_req_wstrb_o = 4'hF;
                    conf_req_valid_o = 1'b1;
                    if (conf_resp_ready_i) begin
                        if (conf_resp_error_i) begin
                            if (RetryEn && retry_q != 2'd3) begin
                                retry_d = retry_q + 2'd1;
                            end else begin
                                state_d = StErr;
                            end
                        end else begin
                            retry_d = '0;
                            idx_d   = idx_q + 1'b1;
                            if (idx_q == LastIdx) begin
                                state_d = (PollMask != '0) ? StPoll : StRun;
                            end
                        end
                    end
                end
            end
            StPoll: begin
                if (poll_gap_q) begin
                    poll_gap_d = 1'b0;
                end else begin
                    conf_req_addr_o  = PollAddr;
                    conf_req_valid_o = 1'b1;
                    if (conf_resp_ready_i) begin
                        if (conf_resp_error_i) begin
                            // a retry goes out back-to-back, without the idle gap
                            if (RetryEn && retry_q != 2'd3) begin
                                retry_d = retry_q + 2'd1;
                            end else begin
                                state_d = StErr;
                            end
                        end else begin
                            retry_d = '0;
                            if ((conf_resp_rdata_i & PollMask) == '0) begin
                                state_d = StRun;
                            end else if (poll_cnt_q + 32'd1 == 32'(PollTimeout)) begin
                                state_d = StErr;
                            end else begin
                                poll_cnt_d = poll_cnt_q + 32'd1;
                                poll_gap_d = 1'b1;
                            end
                        end
                    end
                end
            end
            StRun, StErr: begin
                ext_rsp_rdata_o = conf_resp_rdata_i;
                ext_rsp_error_o = conf_resp_error_i;
                if (arb_found) begin
                    conf_req_addr_o          = ext_req_addr_i[32*arb_gnt +: 32];
                    conf_req_write_o         = ext_req_write_i[arb_gnt];
                    conf_req_wdata_o         = ext_req_wdata_i[32*arb_gnt +: 32];
                    conf_req_wstrb_o         = ext_req_wstrb_i[4*arb_gnt +: 4];
                    conf_req_valid_o         = ext_req_valid_i[arb_gnt];
                    ext_rsp_ready_o[arb_gnt] = conf_resp_ready_i;
                    if (conf_resp_ready_i) begin
                        lock_d   = 1'b0;
                        rr_ptr_d = rr_next;
                    end else if (!lock_q) begin
                        lock_d = 1'b1;
                        gnt_d  = arb_gnt;
                    end
                end
            end
            default: begin
                state_d = StErr;
            end
        endcase
    end

    assign busy_o       = conf_req_valid_o;
    assign init_done_o  = (state_q == StRun) || (state_q == StErr);
    assign init_error_o = (state_q == StErr);

    // State registers; reset restarts the boot sequence from entry 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StInitWr;
            idx_q      <= '0;
            poll_cnt_q <= '0;
            poll_gap_q <= 1'b0;
            retry_q    <= '0;
            armed_q    <= 1'b0;
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            gnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            poll_cnt_q <= poll_cnt_d;
            poll_gap_q <= poll_gap_d;
            retry_q    <= retry_d;
            armed_q    <= 1'b1;
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            gnt_q      <= gnt_d;
        end
    end

endmodule

// File: tb/tb_axi_llc_conf_seq.sv
// Directed bench for axi_llc_conf_seq with a small reactive LLC responder.
module tb_axi_llc_conf_seq;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] ext_addr = '0, ext_wdata = '0;
    logic [1:0]  ext_write = '0, ext_valid = '0;
    logic [7:0]  ext_wstrb = '0;
    logic [31:0] ext_rdata;
    logic        ext_err;
    logic [1:0]  ext_rdy;
    logic [31:0] conf_addr, conf_wdata, llc_rdata;
    logic        conf_write, conf_valid, llc_err, llc_ready;
    logic [3:0]  conf_wstrb;
    logic        init_done, init_error, busy;

    // Second instance: no boot writes, no poll.
    logic [31:0] z_rdata, z_addr, z_wdata;
    logic        z_err, z_rdy, z_write, z_valid, z_done, z_error, z_busy;
    logic [3:0]  z_wstrb;
    logic [31:0] zero32 = '0;
    logic        zero1 = 1'b0, one1 = 1'b1;
    logic [3:0]  zero4 = '0;

    axi_llc_conf_seq #(
        .NumPorts(2), .NumInit(2),
        .InitAddr(64'h0000_0010_0000_0004), .InitData(64'h0000_00FF_0000_0001),
        .PollAddr(32'h80), .PollMask(32'h1), .PollTimeout(5)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .ext_req_addr_i(ext_addr), .ext_req_write_i(ext_write),
        .ext_req_wdata_i(ext_wdata), .ext_req_wstrb_i(ext_wstrb),
        .ext_req_valid_i(ext_valid), .ext_rsp_rdata_o(ext_rdata),
        .ext_rsp_error_o(ext_err), .ext_rsp_ready_o(ext_rdy),
        .conf_req_addr_o(conf_addr), .conf_req_write_o(conf_write),
        .conf_req_wdata_o(conf_wdata), .conf_req_wstrb_o(conf_wstrb),
        .conf_req_valid_o(conf_valid), .conf_resp_rdata_i(llc_rdata),
        .conf_resp_error_i(llc_err), .conf_resp_ready_i(llc_ready),
        .init_done_o(init_done), .init_error_o(init_error), .busy_o(busy)
    );

    axi_llc_conf_seq #(
        .NumPorts(1), .NumInit(0), .PollMask(32'h0)
    ) dut_z (
        .clk_i(clk), .rst_ni(rst_ni),
        .ext_req_addr_i(zero32), .ext_req_write_i(zero1),
        .ext_req_wdata_i(zero32), .ext_req_wstrb_i(zero4),
        .ext_req_valid_i(zero1), .ext_rsp_rdata_o(z_rdata),
        .ext_rsp_error_o(z_err), .ext_rsp_ready_o(z_rdy),
        .conf_req_addr_o(z_addr), .conf_req_write_o(z_write),
        .conf_req_wdata_o(z_wdata), .conf_req_wstrb_o(z_wstrb),
        .conf_req_valid_o(z_valid), .conf_resp_rdata_i(zero32),
        .conf_resp_error_i(zero1), .conf_resp_ready_i(one1),
        .init_done_o(z_done), .init_error_o(z_error), .busy_o(z_busy)
    );

    // LLC responder knobs (driven by the stimulus) and monitor state.
    int lat = 0, busy_cnt = 0, poll_base = 0, err_at = -1;
    int cyc = 0, n_tx = 0, n_polls = 0, wait_cnt = 0, unstable = 0, early_rdy = 0;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] tx_addr[256], tx_wdata[256];
    logic        tx_write[256];
    logic [3:0]  tx_wstrb[256];
    logic [1:0]  tx_rdy[256];
    int          tx_cyc[256];

    // Ready after lat wait cycles; status reads report busy for busy_cnt polls.
    always_comb begin
        llc_ready = conf_valid && (wait_cnt >= lat);
        llc_rdata = (!conf_write && conf_addr == 32'h80 && (n_polls - poll_base) < busy_cnt)
                    ? 32'h1 : 32'h0;
        llc_err   = llc_ready && (n_tx == err_at);
    end

    // Transaction log and protocol watchers.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (conf_valid && llc_ready) begin
            tx_addr[n_tx]  <= conf_addr;
            tx_wdata[n_tx] <= conf_wdata;
            tx_write[n_tx] <= conf_write;
            tx_wstrb[n_tx] <= conf_wstrb;
            tx_rdy[n_tx]   <= ext_rdy;
            tx_cyc[n_tx]   <= cyc;
            n_tx           <= n_tx + 1;
            if (!conf_write && conf_addr == 32'h80) n_polls <= n_polls + 1;
            wait_cnt <= 0;
        end else if (conf_valid) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
        if (prev_pend && (!conf_valid || conf_addr != prev_addr)) unstable <= unstable + 1;
        prev_pend <= conf_valid && !llc_ready;
        prev_addr <= conf_addr;
        if (!init_done && ext_rdy != 2'b00) early_rdy <= early_rdy + 1;
    end

    int n_chk = 0, n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_init(input string tag);
        int k;
        k = 0;
        while (!init_done && k < 300) begin
            step(1);
            k++;
        end
        check_eq(tag, init_done, 1);
    endtask

    int base, done_cyc, e0;

    initial begin
        // Reset values
        step(2);
        check_eq("rst_valid", conf_valid, 0);
        check_eq("rst_addr", conf_addr, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", init_done, 0);
        check_eq("rst_rdy", ext_rdy, 0);
        check_eq("rst_z_done", z_done, 0);

        // Boot writes in order, then 4 polls (busy 3 times)
        busy_cnt  = 3;
        poll_base = n_polls;
        base      = n_tx;
        @(negedge clk) rst_ni = 1'b1;
        step(1);
        check_eq("z_boot_skip", z_done, 1);
        check_eq("z_no_req", z_valid, 0);
        check_eq("wr0_live_addr", conf_addr, 32'h4);
        check_eq("wr0_live_busy", busy, 1);
        wait_init("boot_done");
        done_cyc = cyc;
        check_eq("boot_ntx", n_tx - base, 6);
        check_eq("wr0_addr", tx_addr[base], 32'h4);
        check_eq("wr0_data", tx_wdata[base], 32'h1);
        check_eq("wr0_strb", tx_wstrb[base], 4'hF);
        check_eq("wr0_write", tx_write[base], 1);
        check_eq("wr1_addr", tx_addr[base+1], 32'h10);
        check_eq("wr1_data", tx_wdata[base+1], 32'hFF);
        check_eq("wr_b2b", tx_cyc[base+1] - tx_cyc[base], 1);
        for (int i = 2; i < 6; i++) begin
            check_eq("poll_addr", tx_addr[base+i], 32'h80);
            check_eq("poll_rd", tx_write[base+i], 0);
        end
        check_eq("poll_gap0", tx_cyc[base+3] - tx_cyc[base+2], 2);
        check_eq("poll_gap2", tx_cyc[base+5] - tx_cyc[base+4], 2);
        check_eq("done_cycle", done_cyc, tx_cyc[base+5] + 1);
        check_eq("boot_err", init_error, 0);

        // Two ports contending, LLC ready after 2 wait cycles
        lat       = 2;
        ext_addr  = {32'h200, 32'h100};
        ext_wdata = {32'hB1, 32'hA0};
        ext_write = 2'b01;
        ext_wstrb = 8'h03;
        base      = n_tx;
        ext_valid = 2'b11;
        for (int k = 0; k < 100 && (n_tx - base) < 4; k++) step(1);
        ext_valid = 2'b00;
        check_eq("rr_ntx", n_tx - base, 4);
        check_eq("rr_g0", tx_addr[base], 32'h100);
        check_eq("rr_g1", tx_addr[base+1], 32'h200);
        check_eq("rr_g2", tx_addr[base+2], 32'h100);
        check_eq("rr_g3", tx_addr[base+3], 32'h200);
        check_eq("rr_r0", tx_rdy[base], 2'b01);
        check_eq("rr_r1", tx_rdy[base+1], 2'b10);
        check_eq("rr_r3", tx_rdy[base+3], 2'b10);
        check_eq("rr_wr0", tx_write[base], 1);
        check_eq("rr_wr1", tx_write[base+1], 0);
        check_eq("rr_strb", tx_wstrb[base], 4'h3);
        check_eq("rr_lat", tx_cyc[base+1] - tx_cyc[base], 3);
        check_eq("stable", unstable, 0);

        // Poll timeout; port 1 waits through boot and is served in error state
        @(negedge clk) rst_ni = 1'b0;
        lat       = 0;
        busy_cnt  = 1000;
        poll_base = n_polls;
        ext_valid = 2'b10;
        step(1);
        check_eq("rst2_rdy", ext_rdy, 0);
        check_eq("rst2_valid", conf_valid, 0);
        e0   = early_rdy;
        base = n_tx;
        @(negedge clk) rst_ni = 1'b1;
        wait_init("to_done");
        check_eq("to_err", init_error, 1);
        step(3);
        ext_valid = 2'b00;
        step(1);
        for (int i = 2; i < 7; i++) check_eq("to_poll", tx_addr[base+i], 32'h80);
        check_eq("to_wr0", tx_addr[base], 32'h4);
        check_eq("err_served", tx_addr[base+7], 32'h200);
        check_eq("err_rdy", tx_rdy[base+7], 2'b10);
        check_eq("no_early_rdy", early_rdy, e0);
        check_eq("err_sticky", init_error, 1);

        // Reset during poll restarts the boot; one error on write 0
        @(negedge clk) rst_ni = 1'b0;
        busy_cnt  = 1000;
        poll_base = n_polls;
        step(1);
        base = n_tx;
        @(negedge clk) rst_ni = 1'b1;
        for (int k = 0; k < 100 && !((n_tx - base) >= 3 && conf_valid); k++) step(1);
        check_eq("in_poll", conf_addr, 32'h80);
        rst_ni = 1'b0;
        #1;
        check_eq("mid_rst_valid", conf_valid, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_addr", conf_addr, 0);
        check_eq("mid_rst_done", init_done, 0);
        busy_cnt  = 0;
        poll_base = n_polls;
        base      = n_tx;
        err_at    = n_tx;
        @(negedge clk) rst_ni = 1'b1;
        wait_init("rs_done");
        step(1);
        check_eq("rs_wr0", tx_addr[base], 32'h4);
`ifdef AXI_LLC_CONF_SEQ_RETRY_EN
        check_eq("retry_addr", tx_addr[base+1], 32'h4);
        check_eq("retry_data", tx_wdata[base+1], 32'h1);
        check_eq("retry_wr1", tx_addr[base+2], 32'h10);
        check_eq("retry_poll", tx_addr[base+3], 32'h80);
        check_eq("retry_err", init_error, 0);
`else
        check_eq("noretry_err", init_error, 1);
        check_eq("noretry_ntx", n_tx - base, 1);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_llc_conf_seq.md
Name: axi_llc_conf_seq

Overview:
Configuration front-end for the LLC RegBus port.
- After reset it autonomously issues a parametrised boot write sequence, then polls a status register until the LLC reports idle.
- Once booted, it round-robin arbitrates NumPorts external RegBus masters onto the single LLC config port.
- Sits between the flattened conf_req/conf_resp pins of the LLC synthesis top and SoC-side config masters.

Parameters:
NumPorts, 2, number of external RegBus masters (1..8)
NumInit, 4, number of boot writes (0 allowed)
InitAddr, '0, flat NumInit*32-bit vector; entry i = addr of boot write i
InitData, '0, flat NumInit*32-bit vector; entry i = wdata of boot write i (wstrb 4'hF)
PollAddr, 32'h0, status register polled after boot writes
PollMask, 32'h0, poll ends when (rdata & PollMask)==0; 0 skips POLL
PollTimeout, 1024, max poll reads before error (>=1)

Ports:
clk_i  in  1  rising-edge clock
rst_ni  in  1  asynchronous reset, active low
ext_req_addr_i  in  NumPorts*32  per-port addr
ext_req_write_i  in  NumPorts  per-port write enable
ext_req_wdata_i  in  NumPorts*32  per-port wdata
ext_req_wstrb_i  in  NumPorts*4  per-port wstrb
ext_req_valid_i  in  NumPorts  per-port valid
ext_rsp_rdata_o  out  32  rdata, broadcast to all ports
ext_rsp_error_o  out  1  error, broadcast
ext_rsp_ready_o  out  NumPorts  per-port ready (only granted port)
conf_req_addr_o  out  32  to LLC
conf_req_write_o  out  1  to LLC
conf_req_wdata_o  out  32  to LLC
conf_req_wstrb_o  out  4  to LLC
conf_req_valid_o  out  1  to LLC
conf_resp_rdata_i  in  32  from LLC
conf_resp_error_i  in  1  from LLC
conf_resp_ready_i  in  1  from LLC
init_done_o  out  1  boot finished (success or error)
init_error_o  out  1  boot write errored or poll timed out
busy_o  out  1  transaction in flight on conf port

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset values: all outputs 0. FSM enters INIT_WR with idx=0, poll_cnt=0, rr_ptr=0.
- RegBus rule: valid is held with stable payload until ready is sampled high. Ready/rdata/error are combinational on the request and valid only in the ready cycle.
- FSM states and transitions:
  - INIT_WR: drive write InitAddr[idx]/InitData[idx], wstrb 4'hF, valid=1. On ready:
    - error -> ERR.
    - else idx++.
    - When idx==NumInit: go to POLL if PollMask!=0, else RUN.
    - NumInit==0: leave INIT_WR in the first cycle after reset, issuing no request.
  - POLL: drive read PollAddr. On ready:
    - error -> ERR.
    - (rdata & PollMask)==0 -> RUN.
    - else poll_cnt++; poll_cnt reaching PollTimeout -> ERR.
    - A new read is issued in the following cycle: one idle cycle between polls, valid deasserted.
  - RUN: init_done_o=1. Arbitration rules:
    - When no grant is locked, grant the first valid port searching from rr_ptr upward with wrap.
    - The grant is combinational in that cycle and locked until conf_resp_ready_i.
    - On completion rr_ptr = granted+1 (mod NumPorts).
    - Payload and valid pass through combinationally from the granted port.
    - ext_rsp_ready_o[g] = conf_resp_ready_i; all other ready bits are 0.
  - ERR: init_done_o=1 and init_error_o=1 (sticky until reset). Arbitration runs identically to RUN.
- During INIT_WR/POLL, all ext_rsp_ready_o=0; external requests stall without loss.
- Grant lock: a port dropping valid before ready is a protocol violation. The block keeps its lock regardless.
- Simultaneous valids are served in strict rotation; a single requesting port is served back-to-back.
- busy_o = conf_req_valid_o.
- Reset mid-operation: state is discarded and the boot sequence restarts from idx 0.

Optional Feature:
AXI_LLC_CONF_SEQ_RETRY_EN:
- Defined: a boot write or poll read returning error is reissued, identical request on the next cycle, up to 3 retries per item. The retry counter clears on a success. The 4th consecutive error -> ERR.
- Undefined: the first error -> ERR.

Test Plan:
1. NumInit=2, InitAddr={0x10,0x04}, InitData={0xFF,0x1}, PollMask=0, LLC ready each cycle -> two writes in order, addr 0x04 then 0x10 (entry 0 in LSBs), init_done_o high on the cycle after the 2nd ready, init_error_o=0.
2. PollMask=0x1; LLC returns rdata 0x1 three times, then 0x0 -> exactly 4 poll reads with an idle cycle between each, then RUN.
3. PollTimeout=5 with rdata always 0x1 -> 5 reads, then init_done_o=1 and init_error_o=1; the ext port is afterwards still served.
4. RUN, NumPorts=2, both valid continuously, LLC ready after 2 cycles -> grants alternate 0,1,0,1; each ready lands only on the granted port; payload stable while locked.
5. Port 1 requests during INIT_WR -> ext_rsp_ready_o[1] stays 0 until RUN, then it is served first.
6. rst_ni pulsed low during POLL -> outputs 0 immediately; after release the write sequence restarts at idx 0. With the macro defined, inject one error on write 0 -> the same write is repeated and boot completes without error.
